// File: rtl/multicycle_mainfsm_pkg.sv
// Shared definitions for the multicycle ARM main FSM: state encoding,
// datapath select codes and the Moore control word layout.
package multicycle_mainfsm_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } statetype;

  localparam logic [1:0] SRCA_REG = 2'b00;
  localparam logic [1:0] SRCA_PC  = 2'b01;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] OP_DP     = 2'b00;
  localparam logic [1:0] OP_MEM    = 2'b01;
  localparam logic [1:0] OP_BRANCH = 2'b10;

  typedef struct packed {
    logic       irWrite;
    logic       adrSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] resultSrc;
    logic       nextPC;
    logic       regW;
    logic       memW;
    logic       branch;
    logic       aluOp;
  } ctrl_t;

endpackage

// File: rtl/multicycle_mainfsm_ctrl_rom.sv
// Combinational state-to-control-word lookup; anything outside the defined
// states (including UNKNOWN) yields an all-zero, side-effect-free word.
module fsm_ctrl_rom
  import multicycle_mainfsm_pkg::*;
(
  input  statetype i_state,
  output ctrl_t    o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      FETCH: begin
        o_ctrl.irWrite   = 1'b1;
        o_ctrl.aluSrcA   = SRCA_PC;
        o_ctrl.aluSrcB   = SRCB_FOUR;
        o_ctrl.resultSrc = RES_ALURESULT;
        o_ctrl.nextPC    = 1'b1;
      end
      // PC+8 is formed here so that R15 reads during execute see it
      DECODE: begin
        o_ctrl.aluSrcA   = SRCA_PC;
        o_ctrl.aluSrcB   = SRCB_FOUR;
        o_ctrl.resultSrc = RES_ALURESULT;
      end
      MEMADR: begin
        o_ctrl.aluSrcA = SRCA_REG;
        o_ctrl.aluSrcB = SRCB_IMM;
      end
      MEMRD: o_ctrl.adrSrc = 1'b1;
      MEMWB: begin
        o_ctrl.resultSrc = RES_DATA;
        o_ctrl.regW      = 1'b1;
      end
      MEMWR: begin
        o_ctrl.adrSrc = 1'b1;
        o_ctrl.memW   = 1'b1;
      end
      EXECUTER: begin
        o_ctrl.aluSrcA = SRCA_REG;
        o_ctrl.aluSrcB = SRCB_REG;
        o_ctrl.aluOp   = 1'b1;
      end
      EXECUTEI: begin
        o_ctrl.aluSrcA = SRCA_REG;
        o_ctrl.aluSrcB = SRCB_IMM;
        o_ctrl.aluOp   = 1'b1;
      end
      ALUWB: begin
        o_ctrl.resultSrc = RES_ALUOUT;
        o_ctrl.regW      = 1'b1;
      end
      BRANCH: begin
        o_ctrl.aluSrcA   = SRCA_REG;
        o_ctrl.aluSrcB   = SRCB_IMM;
        o_ctrl.resultSrc = RES_ALURESULT;
        o_ctrl.branch    = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_mainfsm.sv
// Main sequencing FSM of the multicycle ARM controller: state register and
// next-state logic; the Moore control word comes from fsm_ctrl_rom.
module multicycle_mainfsm
  import multicycle_mainfsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [3:0] state
);

  statetype r_state;
  statetype w_nextState;
  ctrl_t    w_ctrl;
  logic     w_unusedFunct;

  // Only I (Funct[5]) and L (Funct[0]) steer the sequence
  assign w_unusedFunct = ^Funct[4:1];

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = FETCH;
    case (r_state)
      FETCH: w_nextState = DECODE;
      DECODE: begin
        case (Op)
          OP_MEM:    w_nextState = MEMADR;
          OP_DP:     w_nextState = Funct[5] ? EXECUTEI : EXECUTER;
          OP_BRANCH: w_nextState = BRANCH;
          default:   w_nextState = UNKNOWN;
        endcase
      end
      MEMADR:   w_nextState = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    w_nextState = MEMWB;
      EXECUTER: w_nextState = ALUWB;
      EXECUTEI: w_nextState = ALUWB;
      default:  w_nextState = FETCH;
    endcase
  end

  fsm_ctrl_rom u_rom (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  assign IRWrite   = w_ctrl.irWrite;
  assign AdrSrc    = w_ctrl.adrSrc;
  assign ALUSrcA   = w_ctrl.aluSrcA;
  assign ALUSrcB   = w_ctrl.aluSrcB;
  assign ResultSrc = w_ctrl.resultSrc;
  assign NextPC    = w_ctrl.nextPC;
  assign RegW      = w_ctrl.regW;
  assign MemW      = w_ctrl.memW;
  assign Branch    = w_ctrl.branch;
  assign ALUOp     = w_ctrl.aluOp;
  assign state     = r_state;

endmodule

// File: tb/tb_multicycle_mainfsm.sv
// Scoreboard bench for multicycle_mainfsm: instruction-level model predicts the
// per-cycle control word; a negedge monitor compares it against the DUT.
module tb_multicycle_mainfsm;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                         S_MEMRD = 4'd3, S_MEMWB = 4'd4, S_MEMWR = 4'd5,
                         S_EXECR = 4'd6, S_EXECI = 4'd7, S_ALUWB = 4'd8,
                         S_BRANCH = 4'd9, S_UNKNOWN = 4'd10;

  typedef struct packed {
    logic [3:0] st;
    logic       irw;
    logic       adr;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic       npc;
    logic       regw;
    logic       memw;
    logic       br;
    logic       aluop;
  } word_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] state;

  int         total = 0;
  int         bad = 0;
  int         cycle = 0;
  bit         running = 1'b0;
  word_t      expQ[$];
  logic [3:0] plan[$];

  multicycle_mainfsm dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .ALUOp     (ALUOp),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Expected control word for each phase of an instruction
  function automatic word_t ctrlFor(input logic [3:0] s);
    word_t w;
    w = '0;
    w.st = s;
    case (s)
      S_FETCH:  begin w.irw = 1; w.srca = 2'b01; w.srcb = 2'b10; w.res = 2'b10; w.npc = 1; end
      S_DECODE: begin w.srca = 2'b01; w.srcb = 2'b10; w.res = 2'b10; end
      S_MEMADR: w.srcb = 2'b01;
      S_MEMRD:  w.adr = 1;
      S_MEMWB:  begin w.res = 2'b01; w.regw = 1; end
      S_MEMWR:  begin w.adr = 1; w.memw = 1; end
      S_EXECR:  w.aluop = 1;
      S_EXECI:  begin w.srcb = 2'b01; w.aluop = 1; end
      S_ALUWB:  w.regw = 1;
      S_BRANCH: begin w.srcb = 2'b01; w.res = 2'b10; w.br = 1; end
      default:  w.st = s;
    endcase
    return w;
  endfunction

  // Phase sequence of a whole instruction, derived from its class
  task automatic planInstr(input logic [1:0] op, input logic [5:0] funct);
    plan.delete();
    plan.push_back(S_FETCH);
    plan.push_back(S_DECODE);
    case (op)
      2'b00: begin
        plan.push_back(funct[5] ? S_EXECI : S_EXECR);
        plan.push_back(S_ALUWB);
      end
      2'b01: begin
        plan.push_back(S_MEMADR);
        if (funct[0]) begin
          plan.push_back(S_MEMRD);
          plan.push_back(S_MEMWB);
        end else begin
          plan.push_back(S_MEMWR);
        end
      end
      2'b10:   plan.push_back(S_BRANCH);
      default: plan.push_back(S_UNKNOWN);
    endcase
  endtask

  // Runs one instruction; resetAt selects the phase during which reset is raised
  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct,
                               input int resetAt);
    logic [3:0] nxt;
    planInstr(op, funct);
    for (int k = 0; k < plan.size(); k++) begin
      if (plan[k] == S_DECODE || plan[k] == S_MEMADR) begin
        Op = op;
        Funct = funct;
      end else begin
        Op = 2'($urandom);
        Funct = 6'($urandom);
      end
      if (k == resetAt) begin
        reset = 1'b1;
        @(posedge clk); #1;
        expQ.push_back(ctrlFor(S_FETCH));
        @(posedge clk); #1;
        expQ.push_back(ctrlFor(S_FETCH));
        reset = 1'b0;
        return;
      end
      @(posedge clk); #1;
      nxt = (k + 1 < plan.size()) ? plan[k + 1] : S_FETCH;
      expQ.push_back(ctrlFor(nxt));
    end
  endtask

  task automatic checkOutput();
    word_t act;
    word_t exp;
    act = {state, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           NextPC, RegW, MemW, Branch, ALUOp};
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL ctrl_underflow cycle=%0d got=%h required=<expectation>", cycle, act);
    end else begin
      exp = expQ.pop_front();
      if (act !== exp) begin
        bad++;
        $display("[TB] FAIL ctrl_word cycle=%0d got state=%0d word=%h required state=%0d word=%h",
                 cycle, act.st, act, exp.st, exp);
      end
    end
  endtask

  always @(negedge clk) begin
    cycle++;
    if (running) checkOutput();
  end

  initial begin
    int resetAt;
    reset = 1'b1;
    Op = 2'b00;
    Funct = 6'b000000;
    @(posedge clk); #1;
    expQ.push_back(ctrlFor(S_FETCH));
    running = 1'b1;
    @(posedge clk); #1;
    expQ.push_back(ctrlFor(S_FETCH));
    reset = 1'b0;

    applyStimulus(2'b00, 6'b001000, -1);
    applyStimulus(2'b00, 6'b111000, -1);
    applyStimulus(2'b01, 6'b011001, -1);
    applyStimulus(2'b01, 6'b011000, -1);
    applyStimulus(2'b10, 6'($urandom), -1);
    applyStimulus(2'b11, 6'($urandom), -1);
    applyStimulus(2'b01, 6'b011000, 3);
    applyStimulus(2'b01, 6'b011001, 3);

    for (int i = 0; i < 120; i++) begin
      resetAt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      applyStimulus(2'($urandom_range(0, 3)), 6'($urandom), resetAt);
    end

    @(negedge clk);
    #1;
    running = 1'b0;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL leftover_expectations got=%0d required=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
